// File: rtl/search_key_fifo.sv
// search_key_fifo
//   Buffers the free-running search-key stream in front of the search RAM
//   engine. A one-entry staging register lets the block see whether the
//   next cycle still carries a key, so each key is pushed one cycle after
//   capture, tagged with "last of burst". Keys go into a show-ahead FIFO
//   drained over a valid/ready handshake. Keys that arrive while the FIFO is
//   full are dropped and counted.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        synchronous clear of staging, FIFO and overflow status
//   search_i/key_i key stream, valid whenever search_i=1, no backpressure
//   key_valid_o/key_o/key_last_o/key_ready_i  FIFO head handshake
//   level_o/full_o/empty_o                    FIFO occupancy
//   overflow_o/drop_cnt_o                     sticky drop flag, saturating count
//
// Optional build macro SEARCH_KEY_FIFO_STATS_EN adds
//   push_cnt_o  wrapping count of successful pushes
//   hwm_o       highest occupancy seen since reset or flush
module search_key_fifo #(
  parameter int C_RULE_WIDTH = 24,
  parameter int C_DEPTH      = 8,
  parameter int C_DROP_CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      search_i,
  input  logic [C_RULE_WIDTH-1:0]   key_i,
  output logic                      key_valid_o,
  output logic [C_RULE_WIDTH-1:0]   key_o,
  output logic                      key_last_o,
  input  logic                      key_ready_i,
  output logic [$clog2(C_DEPTH):0]  level_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      overflow_o,
  output logic [C_DROP_CNT_W-1:0]   drop_cnt_o
`ifdef SEARCH_KEY_FIFO_STATS_EN
  ,
  output logic [31:0]               push_cnt_o,
  output logic [$clog2(C_DEPTH):0]  hwm_o
`endif
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(C_DEPTH);

  // Staging register
  logic                    stg_vld_q, stg_vld_d;
  logic [C_RULE_WIDTH-1:0] stg_key_q, stg_key_d;

  // FIFO state
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic [C_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Storage: {last, key}; not reset, contents only observed while valid.
  logic [C_RULE_WIDTH:0]   mem_q [C_DEPTH];
  logic [C_RULE_WIDTH:0]   head;

  logic full, pop, push_req, push_ok, drop, push_last;

  assign full      = (level_q == DEPTH_L);
  assign pop       = key_valid_o & key_ready_i;
  // The staged key leaves whenever it exists; flush discards it instead.
  assign push_req  = stg_vld_q & ~flush_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  // No key follows this cycle -> the staged key closes its burst.
  assign push_last = ~search_i;

  always_comb begin
    stg_vld_d  = stg_vld_q;
    stg_key_d  = stg_key_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      stg_vld_d  = 1'b0;
      stg_key_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else begin
      stg_vld_d = search_i;
      if (search_i) begin
        stg_key_d = key_i;
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_cnt_q != {C_DROP_CNT_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + C_DROP_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_vld_q  <= 1'b0;
      stg_key_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      stg_key_q  <= stg_key_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_last, stg_key_q};
    end
  end

  // Show-ahead head: read straight from the storage registers; forced to
  // zero while empty so reset and idle outputs are deterministic.
  assign head        = mem_q[rd_ptr_q];
  assign key_valid_o = (level_q != '0);
  assign key_o       = key_valid_o ? head[C_RULE_WIDTH-1:0] : '0;
  assign key_last_o  = key_valid_o & head[C_RULE_WIDTH];
  assign level_o     = level_q;
  assign full_o      = full;
  assign empty_o     = (level_q == '0);
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_cnt_q;

`ifdef SEARCH_KEY_FIFO_STATS_EN
  logic [31:0]   push_cnt_q, push_cnt_d;
  logic [LW-1:0] hwm_q, hwm_d;

  always_comb begin
    push_cnt_d = push_cnt_q;
    hwm_d      = hwm_q;
    if (flush_i) begin
      push_cnt_d = '0;
      hwm_d      = '0;
    end else begin
      if (push_ok) begin
        push_cnt_d = push_cnt_q + 32'd1;
      end
      // Track the occupancy that level_o will show next cycle.
      if (level_d > hwm_q) begin
        hwm_d = level_d;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      push_cnt_q <= '0;
      hwm_q      <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      hwm_q      <= hwm_d;
    end
  end

  assign push_cnt_o = push_cnt_q;
  assign hwm_o      = hwm_q;
`endif

endmodule
